// File: rtl/tone_player_pkg.sv
// Shared types and helpers for the tone_player square-wave note generator.
package tone_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int MIN_HALF = 2;

    function automatic int ticks_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Counter width that stays at least one bit even for a count of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tone_player_if.sv
// Request/response bundle between the sound sequencer and tone_player.
interface tone_player_if #(
    parameter int DIV_W = 15,
    parameter int DUR_W = 10
);
    logic [DIV_W-1:0] half_period;
    logic [DUR_W-1:0] duration_ms;
    logic             start;
    logic             stop;
    logic             speaker;
    logic             busy;
    logic             done;

    modport master (
        output half_period, duration_ms, start, stop,
        input  speaker, busy, done
    );

    modport slave (
        input  half_period, duration_ms, start, stop,
        output speaker, busy, done
    );
endinterface

// File: rtl/tone_player_ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every TICKS cycles, held at zero while cleared.
module ms_tick_gen
    import tone_pkg::*;
#(
    parameter int TICKS = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = cnt_width(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/tone_player.sv
// Timed square-wave note generator: plays half_period-based tones for duration_ms and pulses done.
module tone_player
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 15,
    parameter int DUR_W  = 10
) (
    input  logic         clk,
    input  logic         rst,
    tone_player_if.slave bus
);
    localparam int TICKS = ticks_per_ms(CLK_HZ);

    state_t           r_state;
    logic             r_speaker;
    logic             r_busy;
    logic             r_done;
    logic [DUR_W-1:0] r_dur;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_half;

    logic             w_tick;
    logic             w_clear;
    logic [DIV_W-1:0] w_div_next;

    assign w_clear    = (r_state != PLAY);
    assign w_div_next = (bus.half_period < DIV_W'(MIN_HALF)) ? DIV_W'(MIN_HALF) : bus.half_period;

    ms_tick_gen #(.TICKS(TICKS)) u_ms_tick (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_speaker <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dur     <= '0;
            r_div     <= '0;
            r_half    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.duration_ms == '0) begin
                            // Suppress a second back-to-back done after a note just ended.
                            r_done <= !r_done;
                        end else begin
                            r_state   <= PLAY;
                            r_busy    <= 1'b1;
                            r_speaker <= 1'b1;
                            r_dur     <= bus.duration_ms;
                            r_div     <= w_div_next;
                            r_half    <= '0;
                        end
                    end
                end
                PLAY: begin
                    if (bus.stop || (w_tick && r_dur == DUR_W'(1))) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_speaker <= 1'b0;
                        r_done    <= 1'b1;
                        r_dur     <= '0;
                        r_half    <= '0;
                    end else begin
                        if (w_tick) begin
                            r_dur <= r_dur - 1'b1;
                        end
                        // Retune only at a toggle so the running half wave keeps its length.
                        if (r_half == r_div - 1'b1) begin
                            r_half    <= '0;
                            r_speaker <= !r_speaker;
                            r_div     <= w_div_next;
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.speaker = r_speaker;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player with a behavioural waveform model and randomized notes.
module tb_tone_player;

    localparam int CLK_HZ = 10_000;
    localparam int TICKS  = 10;
    localparam int DIV_W  = 15;
    localparam int DUR_W  = 10;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tone_player_if #(.DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

    tone_player #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampd(input int hp);
        return (hp < 2) ? 2 : hp;
    endfunction

    // Speaker level at play cycle k (1-based): first half wave lasts a cycles, later ones b.
    function automatic logic model_spk(input int k, input int a, input int b);
        if (k <= a) return 1'b1;
        return (((k - a - 1) / b) % 2 == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [2:0] obs();
        return {bus.busy, bus.speaker, bus.done};
    endfunction

    // Plays one note and checks every cycle of it plus the done pulse and the cycle after.
    task automatic play_note(input int hp, input int dur, input string name);
        int         d;
        int         n;
        logic [2:0] exp;
        d = clampd(hp);
        n = dur * TICKS;
        bus.half_period = DIV_W'(hp);
        bus.duration_ms = DUR_W'(dur);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            exp = {1'b1, model_spk(k, d, d), 1'b0};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL %s play cycle %0d: got busy/spk/done=%b expected %b", name, k, obs(), exp);
            end
            step();
        end
        n_tests++;
        if (obs() !== 3'b001) begin
            n_fail++;
            $display("FAIL %s end: got %b expected 001", name, obs());
        end
        step();
        n_tests++;
        if (obs() !== 3'b000) begin
            n_fail++;
            $display("FAIL %s after end: got %b expected 000", name, obs());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.half_period = DIV_W'(3);
        bus.duration_ms = DUR_W'(3);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs() !== 3'b000) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %b expected 000", i, obs());
            end
        end
        rst = 1'b0;
        bus.start = 1'b0;
        step();
        n_tests++;
        if (obs() !== 3'b000) begin
            n_fail++;
            $display("FAIL reset release: got %b expected 000", obs());
        end
    endtask

    task automatic test_basic();
        play_note(3, 4, "basic");
    endtask

    task automatic test_retune();
        logic [2:0] exp;
        bus.half_period = DIV_W'(5);
        bus.duration_ms = DUR_W'(3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 3 * TICKS; k++) begin
            exp = {1'b1, model_spk(k, 5, 2), 1'b0};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL retune cycle %0d: got %b expected %b", k, obs(), exp);
            end
            if (k == 2) bus.half_period = DIV_W'(2);
            step();
        end
        n_tests++;
        if (obs() !== 3'b001) begin
            n_fail++;
            $display("FAIL retune end: got %b expected 001", obs());
        end
        step();
    endtask

    task automatic test_clamp();
        play_note(0, 2, "clamp0");
        play_note(1, 1, "clamp1");
    endtask

    task automatic test_zero_dur();
        bus.half_period = DIV_W'(3);
        bus.duration_ms = DUR_W'(0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (obs() !== 3'b001) begin
            n_fail++;
            $display("FAIL zero_dur pulse: got %b expected 001", obs());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs() !== 3'b000) begin
                n_fail++;
                $display("FAIL zero_dur idle %0d: got %b expected 000", i, obs());
            end
        end
    endtask

    task automatic test_stop();
        logic [2:0] exp;
        bus.half_period = DIV_W'(3);
        bus.duration_ms = DUR_W'(4);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp = {1'b1, model_spk(k, 3, 3), 1'b0};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL stop pre cycle %0d: got %b expected %b", k, obs(), exp);
            end
            if (k < 7) step();
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_tests++;
        if (obs() !== 3'b001) begin
            n_fail++;
            $display("FAIL stop cycle 8: got %b expected 001", obs());
        end
        step();
        n_tests++;
        if (obs() !== 3'b000) begin
            n_fail++;
            $display("FAIL stop after: got %b expected 000", obs());
        end
    endtask

    task automatic test_start_while_busy();
        logic [2:0] exp;
        bus.half_period = DIV_W'(3);
        bus.duration_ms = DUR_W'(2);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 2 * TICKS; k++) begin
            exp = {1'b1, model_spk(k, 3, 3), 1'b0};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL busy_start cycle %0d: got %b expected %b", k, obs(), exp);
            end
            if (k == 5) begin
                bus.start = 1'b1;
                bus.half_period = DIV_W'(7);
                bus.duration_ms = DUR_W'(9);
            end else if (k == 6) begin
                bus.start = 1'b0;
                bus.half_period = DIV_W'(3);
            end
            step();
        end
        n_tests++;
        if (obs() !== 3'b001) begin
            n_fail++;
            $display("FAIL busy_start end: got %b expected 001", obs());
        end
        step();
    endtask

    task automatic test_start_stop_idle();
        bus.half_period = DIV_W'(3);
        bus.duration_ms = DUR_W'(3);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs() !== 3'b000) begin
                n_fail++;
                $display("FAIL start_stop_idle %0d: got %b expected 000", i, obs());
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bus.half_period = DIV_W'(4);
        bus.duration_ms = DUR_W'(3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs() !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid %0d: got %b expected 000", i, obs());
            end
            step();
        end
    endtask

    task automatic test_random_notes();
        for (int i = 0; i < 6; i++) begin
            play_note(int'($urandom_range(0, 9)), int'($urandom_range(1, 3)), "random");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.half_period = '0;
        bus.duration_ms = '0;
        rst = 1'b1;
        test_reset();
        test_basic();
        test_retune();
        test_clamp();
        test_zero_dur();
        test_stop();
        test_start_while_busy();
        test_start_stop_idle();
        test_reset_mid();
        test_random_notes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_player.md
# tone_player

Timed square-wave note generator for the Pacman sound path. It consumes the 15-bit half-period word produced by the button-to-frequency mapper and drives the speaker pin with a square wave. Each note plays for a programmed number of milliseconds, then the block reports completion to the sound sequencer. It sits between the frequency mapper and the speaker output pin.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; sets the number of clocks per millisecond.
- `DIV_W`, 15: width of the half-period word, in clock cycles.
- `DUR_W`, 10: width of the note duration, in ms.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `half_period`  in  DIV_W  clocks per half wave (e.g. 25000 gives 1 kHz at 50 MHz).
- `duration_ms`  in  DUR_W  note length, in ms; sampled on `start`.
- `start`  in  1  single-cycle request to play a note.
- `stop`  in  1  abort the current note.
- `speaker`  out  1  square-wave output.
- `busy`  out  1  high while a note is playing.
- `done`  out  1  one-cycle pulse when a note ends (natural end or stop).

## Operation
- States:
  - IDLE: `speaker`=0, `busy`=0.
  - PLAY: `busy`=1.
- IDLE→PLAY: on `start`=1 with `stop`=0.
  - Captures `duration_ms` into the duration counter.
  - Captures `half_period` into the active divisor.
  - Clears the ms prescaler and the half-wave counter; sets `speaker`=1.
- IDLE with `start`=1 and `duration_ms`=0: stay in IDLE and pulse `done` next cycle. `speaker` stays 0.
- PLAY→IDLE:
  - When the remaining duration reaches 0, or on `stop`=1.
  - `speaker`=0 and `done`=1 for exactly one cycle.
- `start` during PLAY: ignored; no restart and no queueing.
- `start` and `stop` in the same IDLE cycle: `stop` wins; no note is played.
- Half-wave counter:
  - Counts 0..D-1, where D is the active divisor.
  - At D-1 it toggles `speaker` and wraps to 0.
- Retune: `half_period` is re-sampled into the active divisor only at a toggle point. A live change never truncates or stretches the current half wave.
- Clamping: a divisor value below 2 is treated as 2, so the fastest output is clk/4.
- Ms prescaler:
  - Counts 0..TICKS_PER_MS-1, where TICKS_PER_MS = CLK_HZ/1000.
  - On wrap it decrements the remaining duration.
- Arithmetic: all counters are unsigned and never underflow. Prescaler width is $clog2(TICKS_PER_MS).

## Timing
- Reset values: `speaker`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Start latency: `start` sampled at edge t → `busy`=1 and `speaker`=1 from cycle t+1.
- Waveform: `speaker` is high for D cycles, then low for D cycles, repeating. Period is 2D cycles.
- Note length: PLAY lasts exactly duration_ms × TICKS_PER_MS cycles. On the following cycle `busy`=0, `done`=1, `speaker`=0.
- Stop latency: `stop` at cycle s → `busy`=0, `speaker`=0, `done`=1 at s+1.
- `done` is never asserted two cycles in a row.
- `rst` mid-note: outputs go to reset values at the next edge. No `done` pulse is produced.
- `rst` has priority over `start` and `stop`.

## Structure
- Package `tone_pkg` contains:
  - `state_t` enum {IDLE, PLAY}.
  - `MIN_HALF`=2.
  - A function computing TICKS_PER_MS from CLK_HZ.
- Sub-module `ms_tick_gen`:
  - Free prescaler with a synchronous clear.
  - Outputs a one-cycle `tick` every TICKS_PER_MS cycles.
  - Cleared on PLAY entry.
- The top level holds the FSM, the half-wave counter, the divisor register and the duration counter.

## Test plan
- Bench parameters: CLK_HZ=10_000, so TICKS_PER_MS=10.
- Reset: assert `rst` for 3 cycles → `speaker`=0, `busy`=0, `done`=0. Hold `start`=1 during reset → nothing plays.
- Basic note: `half_period`=3, `duration_ms`=4, one-cycle `start` →
  - `busy` high for exactly 40 cycles.
  - `speaker` pattern 111000 repeating.
  - One `done` pulse at cycle 41.
- Retune: in PLAY with D=5, change `half_period` to 2 mid-half-wave → the current half wave still lasts 5 cycles; subsequent half waves last 2 cycles.
- Clamp and zero duration:
  - `half_period`=0, `duration_ms`=2 → half waves of 2 cycles for 20 cycles.
  - `duration_ms`=0 → `busy` never rises; `done` pulses once.
- Abort, collisions and reset:
  - `stop` at cycle 7 of a note → `busy`=0, `speaker`=0, `done`=1 at cycle 8.
  - `start` while busy → ignored.
  - `start`+`stop` together in IDLE → no note.
  - `rst` mid-note → outputs cleared next cycle with no `done`.
